// File: rtl/ds_burst_frame_collector.sv
// ds_burst_frame_collector
//   Re-frames the downstream-burst payload beat stream (valid-only, no
//   backpressure) into a valid/ready stream with last, byte keep, error flag
//   and channel, buffered in an output FIFO. Detects illegal lengths, FIFO
//   overflow and mid-frame timeouts.
//
//   Ports
//     sys_clk_i, rst_n_i        clock, async active-low reset
//     ds_burst_valid_i/data_i   input beat strobe and 128-bit beat (byte 0 at [127:120])
//     field_len_i, channel_i    frame length in bytes and channel, stable per frame
//     m_valid_o/m_ready_i       output handshake; m_data/keep/last/err/channel_o payload
//     frame_done_o              pulse after the final beat of a frame is counted
//     len_err_o/ovf_err_o/tmo_err_o  error pulses
//     good_frame_cnt_o/err_frame_cnt_o  frame statistics (COLLECTOR_STAT_EN)
//
//   Build option: define COLLECTOR_STAT_EN to generate the saturating frame
//   counters; otherwise both counter ports are tied to zero.
module ds_burst_frame_collector #(
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_LEN     = 4096,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic         ds_burst_valid_i,
  input  logic [127:0] ds_burst_data_i,
  input  logic [15:0]  field_len_i,
  input  logic [7:0]   channel_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [127:0] m_data_o,
  output logic [15:0]  m_keep_o,
  output logic         m_last_o,
  output logic         m_err_o,
  output logic [7:0]   m_channel_o,
  output logic         frame_done_o,
  output logic         len_err_o,
  output logic         ovf_err_o,
  output logic         tmo_err_o,
  output logic [15:0]  good_frame_cnt_o,
  output logic [15:0]  err_frame_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         err;
    logic [7:0]   ch;
  } beat_t;

  typedef enum logic { IDLE, COLLECT } state_t;

  // Keep mask for the final beat: top len[3:0] bytes, or all 16 when aligned.
  function automatic logic [15:0] tail_keep(input logic [3:0] r);
    return (r == 4'd0) ? 16'hFFFF : ~(16'hFFFF >> r);
  endfunction

  function automatic beat_t term_beat(input logic [7:0] ch);
    beat_t b;
    b      = '0;
    b.last = 1'b1;
    b.err  = 1'b1;
    b.ch   = ch;
    return b;
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     len_lo_q, len_lo_d;
  logic [7:0]     chan_q, chan_d;
  logic [16:0]    exp_q, exp_d;
  logic [16:0]    cnt_q, cnt_d;
  logic           ferr_q, ferr_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           pend_q, pend_d;
  logic [7:0]     pend_ch_q, pend_ch_d;
  logic           done_q, done_d, len_err_q, len_err_d;
  logic           ovf_q, ovf_d, tmo_err_q, tmo_err_d;

  beat_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    fcnt_q;

  logic           pop, space, pend_push, slot, len_bad;
  logic [16:0]    exp_in;
  logic           beat_v, beat_last, beat_base_err;
  logic [15:0]    beat_keep;
  logic [7:0]     beat_ch;
  logic           push;
  beat_t          push_beat, head;

  assign pop       = m_valid_o & m_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign space     = (fcnt_q != (AW+1)'(FIFO_DEPTH)) | pop;
  // A pending terminator owns the first free slot ahead of any beat.
  assign pend_push = pend_q & space;
  assign slot      = space & ~pend_push;
  assign len_bad   = (field_len_i == 16'd0) || (field_len_i > 16'(MAX_LEN));
  assign exp_in    = ({1'b0, field_len_i} + 17'd15) >> 4;

  always_comb begin
    state_d       = state_q;
    len_lo_d      = len_lo_q;
    chan_d        = chan_q;
    exp_d         = exp_q;
    cnt_d         = cnt_q;
    ferr_d        = ferr_q;
    tmo_d         = tmo_q;
    pend_d        = pend_q;
    pend_ch_d     = pend_ch_q;
    done_d        = 1'b0;
    len_err_d     = 1'b0;
    ovf_d         = 1'b0;
    tmo_err_d     = 1'b0;
    beat_v        = 1'b0;
    beat_last     = 1'b0;
    beat_keep     = 16'hFFFF;
    beat_base_err = 1'b0;
    beat_ch       = chan_q;
    push          = pend_push;
    push_beat     = term_beat(pend_ch_q);
    if (pend_push) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ds_burst_valid_i) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            len_lo_d  = field_len_i[3:0];
            chan_d    = channel_i;
            exp_d     = exp_in;
            cnt_d     = 17'd1;
            tmo_d     = '0;
            beat_v    = 1'b1;
            beat_last = (exp_in == 17'd1);
            beat_keep = beat_last ? tail_keep(field_len_i[3:0]) : 16'hFFFF;
            beat_ch   = channel_i;
            state_d   = beat_last ? IDLE : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (ds_burst_valid_i) begin
          cnt_d         = cnt_q + 17'd1;
          tmo_d         = '0;
          beat_v        = 1'b1;
          beat_last     = ((cnt_q + 17'd1) == exp_q);
          beat_keep     = beat_last ? tail_keep(len_lo_q) : 16'hFFFF;
          beat_base_err = ferr_q;
          if (beat_last) state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          tmo_err_d = 1'b1;
          tmo_d     = '0;
          state_d   = IDLE;
          if (slot) begin
            push      = 1'b1;
            push_beat = term_beat(chan_q);
          end else begin
            pend_d    = 1'b1;
            pend_ch_d = chan_q;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropped beats still advance the frame; a dropped last beat owes a terminator.
    if (beat_v) begin
      if (slot) begin
        push      = 1'b1;
        push_beat = '{data: ds_burst_data_i, keep: beat_keep, last: beat_last,
                      err: beat_last & beat_base_err, ch: beat_ch};
        ferr_d    = beat_base_err;
      end else begin
        ovf_d  = 1'b1;
        ferr_d = 1'b1;
        if (beat_last) begin
          pend_d    = 1'b1;
          pend_ch_d = beat_ch;
        end
      end
      done_d = beat_last;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      len_lo_q  <= '0;
      chan_q    <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      ferr_q    <= 1'b0;
      tmo_q     <= '0;
      pend_q    <= 1'b0;
      pend_ch_q <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      chan_q    <= chan_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      ferr_q    <= ferr_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      pend_ch_q <= pend_ch_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (AW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (AW+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_q] <= push_beat;
  end

  assign head         = mem_q[rd_q];
  assign m_valid_o    = (fcnt_q != '0);
  assign m_data_o     = m_valid_o ? head.data : '0;
  assign m_keep_o     = m_valid_o ? head.keep : '0;
  assign m_last_o     = m_valid_o & head.last;
  assign m_err_o      = m_valid_o & head.err;
  assign m_channel_o  = m_valid_o ? head.ch : '0;
  assign frame_done_o = done_q;
  assign len_err_o    = len_err_q;
  assign ovf_err_o    = ovf_q;
  assign tmo_err_o    = tmo_err_q;

`ifdef COLLECTOR_STAT_EN
  logic [15:0] good_q, bad_q;
  logic        good_inc, bad_inc;

  // ferr_d already reflects a drop of the final beat itself.
  assign good_inc = done_d & ~ferr_d;
  assign bad_inc  = len_err_d | tmo_err_d | (done_d & ferr_d);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (good_inc && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (bad_inc  && bad_q  != 16'hFFFF) bad_q  <= bad_q + 16'd1;
    end
  end

  assign good_frame_cnt_o = good_q;
  assign err_frame_cnt_o  = bad_q;
`else
  assign good_frame_cnt_o = 16'd0;
  assign err_frame_cnt_o  = 16'd0;
`endif

endmodule
